eth_frame_writer: RTL and testbench
===================================

# eth_frame_writer

Parametrised successor to the HLS-generated Ethernet header writer. It latches a header (destination MAC, source MAC, EtherType) and a payload length on a start handshake. It presents the header on the eth_tx valid/ready header channel, then streams the payload bytes from an external synchronous RAM onto the eth_tx AXI-stream payload channel under full backpressure. It sits between the packet-building datapath and the eth_axis_tx/eth_mac framer and returns `done` per frame.

## Interface
Parameters:
- ADDR_W, 11, payload RAM address width; the base address is a port.
- LEN_W, 11, payload length width in bytes; lengths 0..2^LEN_W-1.
- FIFO_DEPTH, 2, skid-FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  frame request; accepted only when `busy`=0
- dest_mac  in  48  latched on start
- src_mac  in  48  latched on start
- eth_type  in  16  latched on start
- base_addr  in  ADDR_W  first payload byte address, latched on start
- pay_len  in  LEN_W  payload bytes, latched on start
- busy  out  1  high from the cycle after start acceptance until `done`
- done  out  1  one-cycle pulse after the frame completes
- s_eth_hdr_valid  out  1  header valid
- s_eth_hdr_ready  in  1  header ready
- s_eth_dest_mac / s_eth_src_mac / s_eth_type  out  48/48/16  latched header fields
- ram_raddr  out  ADDR_W  payload RAM read address
- ram_ren  out  1  read enable; data arrives on ram_rdata exactly 1 cycle later
- ram_rdata  in  8  payload byte
- s_eth_payload_axis_tdata  out  8  payload byte
- s_eth_payload_axis_tvalid  out  1  beat valid
- s_eth_payload_axis_tready  in  1  beat ready
- s_eth_payload_axis_tlast  out  1  last beat of frame
- s_eth_payload_axis_tuser  out  1  always 0

## Operation
- FSM states: IDLE, HDR, PAY, DONE.
- **IDLE:** if `start`, latch all fields and go to HDR. Issue counter = 0; beat counter = effective length.
- **HDR:** hdr_valid=1. On hdr_valid&&hdr_ready, go to PAY. If effective length is 0, go to DONE instead.
- **PAY:** read address = base_addr + issue counter, mod 2^ADDR_W (wraps).
  - Issue a read when issue counter < pay_len and FIFO occupancy + reads in flight < FIFO_DEPTH. Returned bytes enter the FIFO.
  - tvalid = FIFO non-empty. A beat is accepted on tvalid&&tready; each accepted beat decrements the beat counter.
  - tlast = 1 when the beat counter == 1.
  - Reads may also issue during HDR (prefetch).
- **DONE:** done=1 for one cycle, busy=0, then go to IDLE.
- `start` is ignored in HDR/PAY/DONE.
- tdata/tvalid/tlast are held stable while tvalid&&!tready.
- Reset values: busy, done, hdr_valid, tvalid, tlast, tuser, ram_ren all 0. Header outputs 0. ram_raddr 0. FSM in IDLE. FIFO empty.
- Reset mid-frame aborts immediately: no tlast is emitted and no done pulse is produced.

## Timing
- Start accepted at cycle 0 → busy and hdr_valid high at cycle 1.
- Header handshake at cycle h → the first beat can be valid at h+1, because the prefetch hides RAM latency.
- With tready held high, the bridge sustains 1 beat per cycle. An N-byte frame occupies beats h+1..h+N, with done at h+N+1.
- A tready drop never loses or duplicates a byte; the FIFO absorbs the in-flight read.
- Minimum start-to-start spacing: one IDLE cycle after DONE.

## Configuration
- `ETH_FRAME_WRITER_PAD_EN` defined:
  - Effective length = max(pay_len, 46).
  - Beats beyond pay_len carry 0x00 and issue no RAM reads.
  - tlast is on beat 46 for short frames.
  - pay_len=0 still sends 46 zero beats.
- Undefined: effective length = pay_len exactly; pay_len=0 skips PAY.

## Structure
- Package `eth_writer_pkg`:
  - FSM state enum.
  - ETH_MIN_PAYLOAD = 46.
  - MAC_W = 48, TYPE_W = 16.
- Sub-module `eth_payload_fifo`: synchronous FIFO of FIFO_DEPTH x 8 with push/pop/count. It is reused for the skid storage.

## Test plan
- Start with dest=0x0A0B0C0D0E0F, src=0x112233445566, type=0x0800, len=4, base=0x010; RAM[0x10..0x13]=01,02,03,04; all readies high → hdr_valid at cycle 1 with the latched fields; beats 01,02,03,04 on consecutive cycles, tlast on 04; done one cycle later.
- Same frame with hdr_ready low for 5 cycles → hdr_valid and fields held stable; no beats before the handshake.
- len=8 with tready toggling 1,0,0,1,… → exact byte order; no drops or duplicates; tdata stable during stalls.
- base=0x7FE, len=4, ADDR_W=11 → reads 0x7FE, 0x7FF, 0x000, 0x001.
- len=0: without the pad macro → header only, then done. With `ETH_FRAME_WRITER_PAD_EN`, len=3 → 3 RAM bytes then 43 zeros, tlast on beat 46.
- rst asserted during PAY → all outputs at reset values the next cycle; a new start after reset produces a clean frame.

Source files
------------

// File: rtl/eth_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_writer_pkg
// Description : Shared types and constants for the Ethernet frame writer:
//               frame FSM state encoding, header field widths and the
//               minimum Ethernet payload size used by the padding option.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_writer_pkg;

  localparam int MAC_W           = 48;
  localparam int TYPE_W          = 16;
  localparam int ETH_MIN_PAYLOAD = 46;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/eth_payload_fifo.sv
`default_nettype none
// ============================================================================
// Module      : eth_payload_fifo
// Description : Small show-ahead synchronous FIFO (DEPTH x WIDTH) used as the
//               skid storage between the payload RAM and the AXI-stream port.
//               dout_o always presents the oldest entry.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               push_i, din_i  - write strobe and data
//               pop_i          - remove the head entry
//               dout_o         - head entry (valid while !empty_o)
//               count_o        - current occupancy
//               empty_o        - FIFO holds no entries
// Revision    : 1.0 - initial release
// ============================================================================
module eth_payload_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      count_q;
  logic             w_full, w_do_push, w_do_pop;

  assign empty_o   = (count_q == '0);
  assign w_full    = (count_q == (AW+1)'(DEPTH));
  assign w_do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is allowed when the head leaves in the same cycle.
  assign w_do_push = push_i && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wr_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (w_do_push) wr_q <= wr_q + 1'b1;
      if (w_do_pop)  rd_q <= rd_q + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/eth_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : eth_frame_writer
// Description : Latches an Ethernet header and payload descriptor on start,
//               presents the header on a valid/ready channel, then streams
//               payload bytes from a 1-cycle-latency synchronous RAM onto an
//               AXI-stream channel under full backpressure.
//               Optional feature macro: ETH_FRAME_WRITER_PAD_EN pads short
//               payloads with zero bytes up to the Ethernet minimum (46).
// Ports       : clk, rst                     - clock, sync active-high reset
//               start, dest_mac, src_mac,
//               eth_type, base_addr, pay_len - frame request and descriptor
//               busy, done                   - frame status
//               s_eth_hdr_*, s_eth_*         - header channel
//               ram_raddr, ram_ren, ram_rdata- payload RAM read port
//               s_eth_payload_axis_*         - payload AXI-stream
// Revision    : 1.0 - initial release
// ============================================================================
module eth_frame_writer
  import eth_writer_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int LEN_W      = 11,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MAC_W-1:0]  dest_mac,
  input  logic [MAC_W-1:0]  src_mac,
  input  logic [TYPE_W-1:0] eth_type,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  pay_len,
  output logic              busy,
  output logic              done,
  output logic              s_eth_hdr_valid,
  input  logic              s_eth_hdr_ready,
  output logic [MAC_W-1:0]  s_eth_dest_mac,
  output logic [MAC_W-1:0]  s_eth_src_mac,
  output logic [TYPE_W-1:0] s_eth_type,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_ren,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        s_eth_payload_axis_tdata,
  output logic              s_eth_payload_axis_tvalid,
  input  logic              s_eth_payload_axis_tready,
  output logic              s_eth_payload_axis_tlast,
  output logic              s_eth_payload_axis_tuser
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
`ifdef ETH_FRAME_WRITER_PAD_EN
    eff_len = (len < LEN_W'(ETH_MIN_PAYLOAD)) ? LEN_W'(ETH_MIN_PAYLOAD) : len;
`else
    eff_len = len;
`endif
  endfunction

  state_e            state_q, state_d;
  logic [MAC_W-1:0]  dest_q, dest_d, src_q, src_d;
  logic [TYPE_W-1:0] type_q, type_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;       // RAM-backed bytes
  logic [LEN_W-1:0]  eff_q, eff_d;       // bytes on the wire (incl. padding)
  logic [LEN_W-1:0]  issue_q, issue_d;   // FIFO slots issued so far
  logic [LEN_W-1:0]  beats_q, beats_d;   // beats still to be accepted
  logic              inflight_q, inflight_d; // slot whose byte lands this cycle
  logic              pad_q, pad_d;           // that slot is a zero pad byte

  logic              w_slot, w_ren, w_pop, w_fifo_empty;
  logic [ADDR_W-1:0] w_addr;
  logic [CNT_W-1:0]  w_fifo_cnt, w_occ;
  logic [7:0]        w_fifo_dout;

  assign w_pop = (state_q == ST_PAY) && !w_fifo_empty && s_eth_payload_axis_tready;
  // Occupancy net of the beat leaving this cycle; counting the departing beat
  // would leave a bubble every other cycle with a 2-entry FIFO.
  assign w_occ = w_fifo_cnt + CNT_W'(inflight_q) - CNT_W'(w_pop);

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    src_d   = src_q;
    type_d  = type_q;
    base_d  = base_q;
    len_d   = len_q;
    eff_d   = eff_q;
    issue_d = issue_q;
    beats_d = beats_q;
    w_slot  = 1'b0;
    w_ren   = 1'b0;
    w_addr  = base_q + ADDR_W'(issue_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dest_d  = dest_mac;
          src_d   = src_mac;
          type_d  = eth_type;
          base_d  = base_addr;
          len_d   = pay_len;
          eff_d   = eff_len(pay_len);
          beats_d = eff_len(pay_len);
          // First read goes out with the start itself so the byte is already
          // in the FIFO when the header handshake completes.
          w_addr  = base_addr;
          w_slot  = (eff_len(pay_len) != '0);
          w_ren   = (pay_len != '0);
          issue_d = LEN_W'(w_slot);
          state_d = ST_HDR;
        end
      end
      ST_HDR, ST_PAY: begin
        w_slot  = (issue_q < eff_q) && (w_occ < CNT_W'(FIFO_DEPTH));
        w_ren   = w_slot && (issue_q < len_q);
        issue_d = issue_q + LEN_W'(w_slot);
        if (state_q == ST_HDR) begin
          if (s_eth_hdr_ready) begin
            state_d = (eff_q == '0) ? ST_DONE : ST_PAY;
          end
        end else if (w_pop) begin
          beats_d = beats_q - 1'b1;
          if (beats_q == LEN_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    inflight_d = w_slot;
    pad_d      = w_slot && !w_ren;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dest_q     <= '0;
      src_q      <= '0;
      type_q     <= '0;
      base_q     <= '0;
      len_q      <= '0;
      eff_q      <= '0;
      issue_q    <= '0;
      beats_q    <= '0;
      inflight_q <= 1'b0;
      pad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      src_q      <= src_d;
      type_q     <= type_d;
      base_q     <= base_d;
      len_q      <= len_d;
      eff_q      <= eff_d;
      issue_q    <= issue_d;
      beats_q    <= beats_d;
      inflight_q <= inflight_d;
      pad_q      <= pad_d;
    end
  end

  eth_payload_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .din_i   (pad_q ? 8'h00 : ram_rdata),
    .pop_i   (w_pop),
    .dout_o  (w_fifo_dout),
    .count_o (w_fifo_cnt),
    .empty_o (w_fifo_empty)
  );

  assign busy                      = (state_q == ST_HDR) || (state_q == ST_PAY);
  assign done                      = (state_q == ST_DONE);
  assign s_eth_hdr_valid           = (state_q == ST_HDR);
  assign s_eth_dest_mac            = dest_q;
  assign s_eth_src_mac             = src_q;
  assign s_eth_type                = type_q;
  assign ram_ren                   = w_ren;
  assign ram_raddr                 = w_ren ? w_addr : '0;
  assign s_eth_payload_axis_tdata  = w_fifo_dout;
  assign s_eth_payload_axis_tvalid = (state_q == ST_PAY) && !w_fifo_empty;
  assign s_eth_payload_axis_tlast  = s_eth_payload_axis_tvalid && (beats_q == LEN_W'(1));
  assign s_eth_payload_axis_tuser  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_eth_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_frame_writer
// Description : Self-checking bench for eth_frame_writer. A behavioural RAM
//               and a per-frame expected byte/address list (built directly
//               from the frame rules) are compared against the DUT outputs
//               for directed and randomized frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_frame_writer;

  localparam int ADDR_W = 11;
  localparam int LEN_W  = 11;
  localparam int RAM_SZ = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [47:0]       dest_mac = '0, src_mac = '0;
  logic [15:0]       eth_type = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  pay_len = '0;
  logic              busy, done;
  logic              hdr_valid, hdr_ready = 1'b0;
  logic [47:0]       o_dest, o_src;
  logic [15:0]       o_type;
  logic [ADDR_W-1:0] ram_raddr;
  logic              ram_ren;
  logic [7:0]        ram_rdata = '0;
  logic [7:0]        tdata;
  logic              tvalid, tlast, tuser;
  logic              tready = 1'b0;

  logic [7:0] mem [RAM_SZ];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_ren) ram_rdata <= mem[ram_raddr];
  end

  eth_frame_writer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(2)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .start                     (start),
    .dest_mac                  (dest_mac),
    .src_mac                   (src_mac),
    .eth_type                  (eth_type),
    .base_addr                 (base_addr),
    .pay_len                   (pay_len),
    .busy                      (busy),
    .done                      (done),
    .s_eth_hdr_valid           (hdr_valid),
    .s_eth_hdr_ready           (hdr_ready),
    .s_eth_dest_mac            (o_dest),
    .s_eth_src_mac             (o_src),
    .s_eth_type                (o_type),
    .ram_raddr                 (ram_raddr),
    .ram_ren                   (ram_ren),
    .ram_rdata                 (ram_rdata),
    .s_eth_payload_axis_tdata  (tdata),
    .s_eth_payload_axis_tvalid (tvalid),
    .s_eth_payload_axis_tready (tready),
    .s_eth_payload_axis_tlast  (tlast),
    .s_eth_payload_axis_tuser  (tuser)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int eff_of(input int len);
`ifdef ETH_FRAME_WRITER_PAD_EN
    return (len < 46) ? 46 : len;
`else
    return len;
`endif
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_done"},   done, 0);
    chk({tag, "_hvalid"}, hdr_valid, 0);
    chk({tag, "_tvalid"}, tvalid, 0);
    chk({tag, "_tlast"},  tlast, 0);
    chk({tag, "_tuser"},  tuser, 0);
    chk({tag, "_ren"},    ram_ren, 0);
    chk({tag, "_raddr"},  ram_raddr, 0);
    chk({tag, "_dest"},   o_dest, 0);
    chk({tag, "_src"},    o_src, 0);
    chk({tag, "_type"},   o_type, 0);
  endtask

  // mode 0: tready always high; 1: tready pattern 1,0,0 repeating; 2: random
  task automatic run_frame(input logic [47:0] d, input logic [47:0] s,
                           input logic [15:0] t, input int base, input int len,
                           input int mode, input int hdr_delay);
    byte unsigned exp_q[$];
    int           exp_addr[$];
    int           eff, beat, rd, h, done_k, hdr_cyc;
    bit           hdr_seen, stalled;
    logic [7:0]   held;
    eff = eff_of(len);
    beat = 0; rd = 0; h = -1; done_k = -1; hdr_cyc = 0;
    hdr_seen = 0; stalled = 0; held = '0;
    for (int i = 0; i < eff; i++)
      exp_q.push_back((i < len) ? mem[(base + i) % RAM_SZ] : 8'h00);
    for (int i = 0; i < len; i++)
      exp_addr.push_back((base + i) % RAM_SZ);

    for (int k = 0; k < 4000 && done_k < 0; k++) begin
      @(negedge clk);
      start = (k == 0);
      if (k == 0) begin
        dest_mac  = d;
        src_mac   = s;
        eth_type  = t;
        base_addr = ADDR_W'(base);
        pay_len   = LEN_W'(len);
      end else begin
        dest_mac  = 48'($urandom());
        pay_len   = LEN_W'($urandom());
        base_addr = ADDR_W'($urandom());
      end
      hdr_ready = (hdr_cyc >= hdr_delay);
      case (mode)
        0:       tready = 1'b1;
        1:       tready = (k % 3 == 0);
        default: tready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (k == 0) chk("busy_at_start", busy, 0);
      if (k == 1) chk("hdr_valid_c1", hdr_valid, 1);
      chk("tuser", tuser, 0);
      if (ram_ren) begin
        if (rd < exp_addr.size()) chk("raddr", ram_raddr, exp_addr[rd]);
        else chk("extra_read", 1, 0);
        rd++;
      end
      if (!hdr_seen) chk("tvalid_before_hdr", tvalid, 0);
      if (hdr_valid) begin
        chk("dest", o_dest, d);
        chk("src",  o_src,  s);
        chk("type", o_type, t);
        if (hdr_ready) begin
          hdr_seen = 1;
          h = k;
        end
        hdr_cyc++;
      end
      if (stalled) begin
        chk("stall_valid", tvalid, 1);
        chk("stall_data", tdata, held);
      end
      if (tvalid) begin
        if (beat < eff) begin
          chk("tdata", tdata, exp_q[beat]);
          chk("tlast", tlast, (beat == eff - 1));
        end else begin
          chk("extra_beat", 1, 0);
        end
        if (mode == 0) chk("beat_timing", k, h + 1 + beat);
        stalled = !tready;
        held    = tdata;
        if (tready) beat++;
      end else begin
        stalled = 0;
      end
      if (done) begin
        done_k = k;
        chk("busy_at_done", busy, 0);
        chk("beat_count", beat, eff);
        chk("read_count", rd, len);
        if (mode == 0) chk("done_timing", k, h + eff + 1);
      end else if (k >= 1) begin
        chk("busy", busy, 1);
      end
    end
    start = 1'b0;
    if (done_k < 0) chk("frame_timeout", 0, 1);
  endtask

  initial begin : main
    bit saw_done, saw_valid;
    for (int i = 0; i < RAM_SZ; i++) mem[i] = 8'($urandom());
    mem[16'h010] = 8'h01; mem[16'h011] = 8'h02;
    mem[16'h012] = 8'h03; mem[16'h013] = 8'h04;

    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed frames
    run_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 16'h010, 4, 0, 0);
    run_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 16'h010, 4, 0, 5);
    run_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h86DD, 16'h123, 8, 1, 0);
    run_frame(48'h000000000001, 48'h000000000002, 16'h0806, 16'h7FE, 4, 0, 0);
    run_frame(48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0800, 16'h055, 0, 0, 2);
    run_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 16'h200, 3, 0, 0);

    // Reset during PAY aborts the frame
    @(negedge clk);
    dest_mac = 48'hDEADBEEF0001; src_mac = 48'hCAFE00000002; eth_type = 16'h0800;
    base_addr = 11'h300; pay_len = 11'd30; start = 1'b1; hdr_ready = 1'b1; tready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    chk("abort_in_pay", tvalid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    saw_done = 0; saw_valid = 0;
    repeat (60) begin
      @(negedge clk);
      #1;
      if (done) saw_done = 1;
      if (tvalid || tlast) saw_valid = 1;
    end
    chk("abort_no_done", saw_done, 0);
    chk("abort_no_beat", saw_valid, 0);

    run_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 16'h010, 4, 0, 0);

    // Randomized frames
    for (int n = 0; n < 16; n++) begin
      run_frame({$urandom(), $urandom()}, {$urandom(), $urandom()}, 16'($urandom()),
                int'($urandom_range(0, RAM_SZ - 1)), int'($urandom_range(0, 60)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
